// File: rtl/core_to_axi.sv
// core_to_axi: captures a finished Ising sample and streams it to the host as header, spin words and trailer
module core_to_axi #(
    parameter int DATA_WIDTH = 32,
    parameter int ARRAY_SIZE = 64
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  res_valid,
    input  logic [ARRAY_SIZE-1:0] res_spins,
    input  logic [DATA_WIDTH-1:0] res_problem_id,
    input  logic [DATA_WIDTH-1:0] res_fail_count,
    output logic                  res_busy,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  frame_done,
    output logic [7:0]            drop_count,
    input  logic                  drop_clear
);
    localparam int NUM_WORDS = ARRAY_SIZE / DATA_WIDTH;
    localparam int IW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, HEADER, DATA, TRAILER} state_t;

    state_t                state, state_n;
    logic [ARRAY_SIZE-1:0] spins_q, spins_n;
    logic [DATA_WIDTH-1:0] fail_q, fail_n, data_n;
    logic [IW-1:0]         idx, idx_n;
    logic                  last_n, done_n, hs, drop;
    logic [7:0]            drop_n;

    assign hs   = m_valid && m_ready;
    assign drop = res_valid && state != IDLE;

    // frame sequencing: capture in IDLE, then preload the next word on every accepted beat
    always_comb begin
        state_n = state;
        spins_n = spins_q;
        fail_n  = fail_q;
        data_n  = m_data;
        last_n  = m_last;
        idx_n   = idx;
        done_n  = 1'b0;
        case (state)
            IDLE: if (res_valid) begin
                state_n = HEADER;
                spins_n = res_spins;
                fail_n  = res_fail_count;
                data_n  = res_problem_id;
            end
            HEADER: if (hs) begin
                state_n = DATA;
                idx_n   = '0;
                data_n  = spins_q[DATA_WIDTH-1:0];
            end
            DATA: if (hs) begin
                if (idx == IW'(NUM_WORDS - 1)) begin
                    state_n = TRAILER;
                    data_n  = fail_q;
                    last_n  = 1'b1;
                end else begin
                    idx_n  = idx + 1'b1;
                    data_n = DATA_WIDTH'(spins_q >> ((32'(idx) + 1) * DATA_WIDTH));
                end
            end
            TRAILER: if (hs) begin
                state_n = IDLE;
                data_n  = '0;
                last_n  = 1'b0;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        drop_n = drop_clear ? {7'd0, drop} : drop_count + {7'd0, drop && drop_count != 8'hFF};
    end

    // registered state and outputs; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state      <= IDLE;
            spins_q    <= '0;
            fail_q     <= '0;
            idx        <= '0;
            m_data     <= '0;
            m_last     <= 1'b0;
            m_valid    <= 1'b0;
            res_busy   <= 1'b0;
            frame_done <= 1'b0;
            drop_count <= '0;
        end else begin
            state      <= state_n;
            spins_q    <= spins_n;
            fail_q     <= fail_n;
            idx        <= idx_n;
            m_data     <= data_n;
            m_last     <= last_n;
            m_valid    <= state_n != IDLE;
            res_busy   <= state_n != IDLE;
            frame_done <= done_n;
            drop_count <= drop_n;
        end
    end
endmodule

// File: tb/tb_core_to_axi.sv
// tb_core_to_axi: scoreboard bench for the result-readout stream transmitter
module tb_core_to_axi;
    logic         clk = 1'b0, resetb = 1'b0;
    logic         res_valid = 1'b0, m_ready = 1'b1, drop_clear = 1'b0;
    logic [63:0]  res_spins = '0;
    logic [31:0]  res_problem_id = '0, res_fail_count = '0;
    logic         res_busy, m_valid, m_last, frame_done;
    logic [31:0]  m_data;
    logic [7:0]   drop_count;
    logic         res_valid2 = 1'b0;
    logic [127:0] res_spins2 = '0;
    logic         res_busy2, m_valid2, m_last2, frame_done2;
    logic [31:0]  m_data2;
    logic [7:0]   drop_count2;

    int           checks = 0, errors = 0, cyc = 0, done_cyc = -1, done2_cyc = -1;
    logic [32:0]  exp_q[$], exp2_q[$];
    logic         pend = 1'b0, exp_done = 1'b0;
    logic [32:0]  pend_beat;
    bit           bp [7] = '{1, 0, 0, 1, 0, 1, 1};

    core_to_axi dut (
        .clk(clk), .resetb(resetb), .res_valid(res_valid), .res_spins(res_spins),
        .res_problem_id(res_problem_id), .res_fail_count(res_fail_count), .res_busy(res_busy),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_data(m_data),
        .frame_done(frame_done), .drop_count(drop_count), .drop_clear(drop_clear)
    );

    core_to_axi #(.DATA_WIDTH(32), .ARRAY_SIZE(128)) dut2 (
        .clk(clk), .resetb(resetb), .res_valid(res_valid2), .res_spins(res_spins2),
        .res_problem_id(res_problem_id), .res_fail_count(res_fail_count), .res_busy(res_busy2),
        .m_valid(m_valid2), .m_ready(1'b1), .m_last(m_last2), .m_data(m_data2),
        .frame_done(frame_done2), .drop_count(drop_count2), .drop_clear(1'b0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor for the default instance: beat order, stall stability, frame_done pulse
    always @(negedge clk) begin
        if (!resetb) begin
            pend = 1'b0;
            exp_done = 1'b0;
        end else begin
            check("frame_done", frame_done, exp_done);
            if (frame_done) done_cyc = cyc;
            exp_done = 1'b0;
            if (pend) check("stall hold", {m_valid, m_last, m_data}, {1'b1, pend_beat});
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected beat: got %0h expected none", {m_last, m_data});
                end else begin
                    pend_beat = exp_q.pop_front();
                    check("beat", {m_last, m_data}, pend_beat);
                    exp_done = pend_beat[32];
                end
                pend = 1'b0;
            end else begin
                pend = m_valid;
                pend_beat = {m_last, m_data};
            end
        end
    end

    // monitor for the 128-spin instance, always ready
    always @(negedge clk) begin
        if (resetb) begin
            if (frame_done2) done2_cyc = cyc;
            if (m_valid2) begin
                if (exp2_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected beat128: got %0h expected none", {m_last2, m_data2});
                end else check("beat128", {m_last2, m_data2}, exp2_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [63:0] s, input logic [31:0] id, input logic [31:0] f);
        res_spins = s;
        res_problem_id = id;
        res_fail_count = f;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic strobe(input logic [63:0] s, input logic [31:0] id, input logic [31:0] f, output int t);
        exp_q.push_back({1'b0, id});
        exp_q.push_back({1'b0, s[31:0]});
        exp_q.push_back({1'b0, s[63:32]});
        exp_q.push_back({1'b1, f});
        t = cyc;
        pulse(s, id, f);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [127:0] s2;
        repeat (3) tick();
        check("reset outs", {m_valid, m_last, m_data, res_busy, frame_done, drop_count}, 0);
        check("reset outs128", {m_valid2, m_last2, m_data2, res_busy2, frame_done2, drop_count2}, 0);
        resetb = 1'b1;
        tick();

        strobe(64'h89AB_CDEF_0123_4567, 32'h5, 32'h3, t);
        check("busy after strobe", {res_busy, m_valid, m_data}, {2'b11, 32'h5});
        repeat (8) tick();
        check("basic latency", done_cyc - t, 5);
        check("basic drained", exp_q.size(), 0);

        strobe(64'h89AB_CDEF_0123_4567, 32'h5, 32'h3, t);
        foreach (bp[i]) begin
            m_ready = bp[i];
            tick();
        end
        m_ready = 1'b1;
        repeat (5) tick();
        check("backpressure latency", done_cyc - t, 8);
        check("backpressure drained", exp_q.size(), 0);

        strobe(64'h1111_2222_3333_4444, 32'h7, 32'h9, t);
        pulse(64'hAAAA_AAAA_AAAA_AAAA, 32'hE1, 32'hF1);
        tick();
        pulse(64'hBBBB_BBBB_BBBB_BBBB, 32'hE2, 32'hF2);
        pulse(64'hCCCC_CCCC_CCCC_CCCC, 32'hE3, 32'hF3);
        check("done at trailer", {frame_done, res_busy}, 2'b10);
        check("drop count 3", drop_count, 3);
        strobe(64'h5555_6666_7777_8888, 32'h8, 32'h0, t);
        repeat (8) tick();
        check("restart latency", done_cyc - t, 5);
        check("drops drained", exp_q.size(), 0);

        m_ready = 1'b0;
        strobe(64'hDEAD_BEEF_CAFE_F00D, 32'h21, 32'h42, t);
        repeat (300) pulse(64'h0, 32'h1, 32'h1);
        check("drop saturate", drop_count, 255);
        drop_clear = 1'b1;
        pulse(64'h0, 32'h1, 32'h1);
        check("clear with drop", drop_count, 1);
        tick();
        drop_clear = 1'b0;
        check("clear alone", drop_count, 0);
        check("clear keeps frame", {m_valid, m_data}, {1'b1, 32'h21});
        m_ready = 1'b1;
        repeat (8) tick();
        check("stall drained", exp_q.size(), 0);

        strobe(64'h0F0F_0F0F_F0F0_F0F0, 32'h33, 32'h44, t);
        pulse(64'h1, 32'h2, 32'h3);
        check("drop before reset", drop_count, 1);
        m_ready = 1'b0;
        resetb = 1'b0;
        tick();
        resetb = 1'b1;
        check("midframe reset outs", {m_valid, m_last, m_data, res_busy, frame_done, drop_count}, 0);
        check("reset pending beats", exp_q.size(), 3);
        exp_q.delete();
        m_ready = 1'b1;
        tick();
        strobe(64'h0246_8ACE_1357_9BDF, 32'h66, 32'h77, t);
        repeat (8) tick();
        check("post reset latency", done_cyc - t, 5);
        check("post reset drained", exp_q.size(), 0);

        s2 = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
        res_spins2 = s2;
        res_problem_id = 32'hA;
        res_fail_count = 32'hB;
        exp2_q.push_back({1'b0, 32'hA});
        for (int i = 0; i < 4; i++) exp2_q.push_back({1'b0, s2[i*32 +: 32]});
        exp2_q.push_back({1'b1, 32'hB});
        t = cyc;
        res_valid2 = 1'b1;
        tick();
        res_valid2 = 1'b0;
        repeat (10) tick();
        check("sweep latency", done2_cyc - t, 7);
        check("sweep drained", exp2_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
